// File: rtl/fb_if.sv
// Read port between the scan-out reader and the downscaled framebuffer BRAM.
// The BRAM answers fb_addr/fb_rd_en with fb_data one clock later.
interface fb_if #(
  parameter int ADDR_W = 15
);
  logic [ADDR_W-1:0] fb_addr;
  logic              fb_rd_en;
  logic [11:0]       fb_data;

  modport master (output fb_addr, output fb_rd_en, input fb_data);
  modport slave  (input fb_addr, input fb_rd_en, output fb_data);
endinterface

// File: rtl/vga_fb_reader.sv
// VGA 640x480@60 scan-out: raster counters, multiplier-free framebuffer addressing,
// and a three-stage pipeline that keeps rgb/de/hsync/vsync/frame_start aligned.
module vga_fb_reader #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDR_W      = 15
) (
  input  logic        clk,
  input  logic        rst,
  fb_if.master        fb,
  output logic [11:0] rgb,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);

  typedef logic [H_W-1:0]    h_t;
  typedef logic [V_W-1:0]    v_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam h_t    H_LAST   = h_t'(H_TOTAL - 1);
  localparam h_t    H_VIS    = h_t'(H_ACTIVE);
  localparam h_t    HS_START = h_t'(H_ACTIVE + H_FP);
  localparam h_t    HS_END   = h_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam h_t    H_SUB    = h_t'((1 << SCALE_SHIFT) - 1);
  localparam v_t    V_LAST   = v_t'(V_TOTAL - 1);
  localparam v_t    V_VIS    = v_t'(V_ACTIVE);
  localparam v_t    VS_START = v_t'(V_ACTIVE + V_FP);
  localparam v_t    VS_END   = v_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam v_t    V_SUB    = v_t'((1 << SCALE_SHIFT) - 1);
  localparam addr_t ROW_STEP = addr_t'(H_ACTIVE >> SCALE_SHIFT);

  // Control bits that travel alongside the pixel through the BRAM latency.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};

  h_t    h_cnt;
  v_t    v_cnt;
  addr_t col_addr;
  addr_t row_base;
  ctl_t  ctl_s1;
  ctl_t  ctl_s2;

  logic visible, h_wrap, v_wrap, hs_n, vs_n, first_px;

  always_comb begin
    visible  = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    h_wrap   = (h_cnt == H_LAST);
    v_wrap   = (v_cnt == V_LAST);
    hs_n     = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    vs_n     = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    first_px = (h_cnt == '0) && (v_cnt == '0);
  end

  // Column advances once per 2^S visible clocks; row base steps once per 2^S lines.
  always_ff @(posedge clk) begin
    // NOTE: state uses <= so every flop samples pre-edge values; reset is
    // synchronous, so it is just the first branch inside the clocked block.
    if (rst) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      col_addr <= '0;
      row_base <= '0;
    end else if (h_wrap) begin
      h_cnt    <= '0;
      col_addr <= '0;
      if (v_wrap) begin
        v_cnt    <= '0;
        row_base <= '0;
      end else begin
        v_cnt <= v_cnt + v_t'(1);
        if ((v_cnt < V_VIS) && ((v_cnt & V_SUB) == V_SUB))
          row_base <= row_base + ROW_STEP;
      end
    end else begin
      h_cnt <= h_cnt + h_t'(1);
      if (visible && ((h_cnt & H_SUB) == H_SUB))
        col_addr <= col_addr + addr_t'(1);
    end
  end

  // Stage 1: BRAM request plus the control bits for the same pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      fb.fb_addr  <= '0;
      fb.fb_rd_en <= 1'b0;
      ctl_s1      <= CTL_IDLE;
    end else begin
      fb.fb_rd_en <= visible;
      // NOTE: no else branch: fb_addr is a clock-enabled flop that holds its
      // value through blanking, not a latch.
      if (visible)
        fb.fb_addr <= row_base + col_addr;
      ctl_s1 <= '{de: visible, hs: hs_n, vs: vs_n, fs: first_px};
    end
  end

  // Stage 2 waits out the BRAM read; stage 3 registers all pins together.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_s2      <= CTL_IDLE;
      rgb         <= '0;
      de          <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      ctl_s2      <= ctl_s1;
      rgb         <= ctl_s2.de ? fb.fb_data : 12'h000;
      de          <= ctl_s2.de;
      hsync       <= ctl_s2.hs;
      vsync       <= ctl_s2.vs;
      frame_start <= ctl_s2.fs;
    end
  end

endmodule

// File: doc/vga_fb_reader.md
Name: vga_fb_reader

Overview:
- Scan-out end of the VGA path: generates 640x480@60 timing on a 25 MHz pixel clock.
- Reads 12-bit RGB pixels from a downscaled framebuffer BRAM (synchronous read) and drives hsync, vsync and the display-enable / rgb pins.
- The pixel-layer selector and the colour mux consume its rgb output.
- Counterpart to the framebuffer writer: this block is the reader side of that BRAM.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SCALE_SHIFT, 2, log2 of pixel replication; framebuffer is (H_ACTIVE>>S) x (V_ACTIVE>>S)
- ADDR_W, 15, framebuffer address width (must hold 160*120-1 = 19199)

Ports:
- clk  in  1  pixel clock, 25 MHz
- rst  in  1  synchronous, active-high reset
- fb_addr  out  ADDR_W  framebuffer read address (registered)
- fb_rd_en  out  1  read strobe, high only for visible pixels
- fb_data  in  12  pixel returned by BRAM one clock after fb_addr/fb_rd_en
- rgb  out  12  {R[3:0],G[3:0],B[3:0]}; 12'h000 whenever de=0
- de  out  1  display enable, aligned with rgb
- hsync  out  1  active-low, aligned with rgb
- vsync  out  1  active-low, aligned with rgb
- frame_start  out  1  one-clock pulse on the first visible pixel of each frame, aligned with rgb

Behaviour:
- Counters:
  - h_cnt runs 0..H_TOTAL-1, H_TOTAL = 800.
  - v_cnt runs 0..V_TOTAL-1, V_TOTAL = 525; it increments when h_cnt wraps, and both wrap to 0 together at frame end.
- Visible region is h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- hsync is low while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
- vsync is low while V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
- Address generation, no multiplier:
  - col_addr increments every 2^S visible clocks.
  - row_base increases by H_ACTIVE>>S only when v_cnt crosses a 2^S line boundary.
  - row_base resets to 0 at frame wrap; col_addr resets to 0 at each line wrap.
  - fb_addr = row_base + col_addr.
- Pipeline, total latency L=3 clocks from counter state to pins:
  - Stage 1: fb_addr and fb_rd_en registered from the counters.
  - Stage 2: BRAM returns fb_data.
  - Stage 3: rgb, de, hsync, vsync and frame_start registered together. Sync and de are delayed through a matching 2-deep shift register so all pins stay mutually aligned.
- rgb = fb_data when the delayed de=1, else 12'h000. fb_data is ignored when de=0.
- fb_rd_en=0 and fb_addr holds its last value during blanking.
- Reset values, forced at the clock edge where rst=1:
  - h_cnt=0, v_cnt=0, row_base=0, col_addr=0.
  - fb_addr=0, fb_rd_en=0.
  - rgb=0, de=0, hsync=1, vsync=1, frame_start=0.
  - All pipeline stages cleared.
- Reset mid-line or mid-frame: outputs take their reset values on the next edge. Scanning restarts at pixel (0,0) on the first edge with rst=0. No partial-frame state survives.
- Frame wrap (h_cnt=799, v_cnt=524) and line wrap occur in the same cycle; row_base and col_addr clear together, with no off-by-one line.
- Duplicate addresses are issued 2^S times per column and per row; this is required behaviour, not an error.

Test Plan:
- Reset behaviour: hold rst=1 for 5 clocks -> rgb=000, de=0, hsync=1, vsync=1, fb_rd_en=0, fb_addr=0.
- Horizontal timing: release rst at edge 0 ->
  - de high for edges 3..642;
  - hsync low for exactly 96 clocks starting at edge 659;
  - line period 800 clocks.
- Vertical timing and frame period:
  - vsync low for exactly 2*800 = 1600 clocks, starting at line 490;
  - frame_start pulses every 420000 clocks, exactly once per frame, coincident with the first de=1.
- Address mapping (BRAM model returning data = address[11:0]):
  - pixel (x=4,y=4) -> rgb=12'h0A1 (addr 161);
  - pixel (639,479) -> addr 19199 -> rgb=12'hAFF;
  - pixels x=0..3 on line 0 -> addr 0 each.
- Blanking: BRAM model drives fb_data=12'hFFF constantly -> rgb=000 whenever de=0, and rgb=FFF for all visible pixels.
- Reset mid-frame: assert rst for 1 clock at line 200, pixel 300 -> next edge shows reset values; after release de rises 3 clocks later with fb_addr restarting at 0.
